cu_mc: RTL and testbench
========================

Name: cu_mc

Overview:
Multi-cycle control unit for the RV32I core. A state machine sequences FETCH/DECODE/EXEC/MEM/WB with ready/request handshakes to instruction and data memory. The block latches decoded datapath controls per instruction and pulses the architectural write strobes only in their owning state. It also detects illegal encodings and memory timeouts, and keeps a retired-instruction counter.

Parameters:
MEM_TIMEOUT, 16, max cycles waiting for imem_ready/dmem_ready before bus error; 0 disables watchdog
TO_W, 5, width of watchdog counter; must satisfy 2**TO_W > MEM_TIMEOUT
CNT_W, 32, width of instret counter

Ports:
clk  in  1  core clock
rst  in  1  synchronous active-high reset
opcode  in  7  instruction opcode from IR, valid from DECODE onward
funct3  in  3  instruction funct3 from IR
funct7  in  7  instruction funct7 from IR
imem_ready  in  1  instruction memory data valid
dmem_ready  in  1  data memory access complete
imem_req  out  1  instruction fetch request
dmem_req  out  1  data memory request
ir_we  out  1  instruction register load strobe
pc_we  out  1  PC update strobe (instruction retire)
RUWr  out  1  register-file write strobe
DmWr  out  1  data memory write strobe
ImmSrc  out  3  immediate format select
AluAsrc  out  1  ALU A: 0=rs1, 1=PC
AluBsrc  out  1  ALU B: 0=rs2, 1=imm
AluOp  out  4  ALU operation
BrOp  out  5  branch unit operation
DmCtrl  out  3  memory access size/sign
RUDataWrSrc  out  2  write-back select: 00 ALU, 01 mem, 10 PC+4
illegal  out  1  sticky illegal-instruction flag
bus_err  out  1  sticky memory timeout flag
instret  out  CNT_W  retired instruction count
state_o  out  3  current FSM state (debug)

Behaviour:
- Reset (synchronous, rst=1 at posedge): state=FETCH, all strobes 0, all latched controls 0, illegal=0, bus_err=0, instret=0, watchdog=0. Reset mid-instruction abandons the instruction with no write.
- States: FETCH, DECODE, EXEC, MEM, WB, TRAP.
- FETCH: imem_req=1. On imem_ready=1: ir_we=1 in the same cycle, then go to DECODE. Otherwise stay.
- DECODE: 1 cycle. Run the combinational decode and latch ImmSrc/AluAsrc/AluBsrc/AluOp/BrOp/DmCtrl/RUDataWrSrc. If the encoding is illegal, set illegal=1 and go to TRAP.
- Encodings:
  - R-type: AluOp={f7[5],f3}.
  - I-arith: AluOp={f3==101 ? f7[5] : 0, f3}, AluBsrc=1.
  - Load: AluBsrc=1, DmCtrl=f3, src=01.
  - Store: ImmSrc=001, AluBsrc=1, DmCtrl=f3.
  - Branch: ImmSrc=010, AluOp=1000, BrOp={2'b01,f3}.
  - JAL: ImmSrc=100, AluAsrc=1, AluBsrc=1, BrOp=10000, src=10.
  - JALR: AluBsrc=1, BrOp=10000, src=10.
  - LUI/AUIPC: ImmSrc=011, AluAsrc=1, AluBsrc=1.
  - All unlisted fields are 0.
- Illegal encodings:
  - unknown opcode;
  - R-type with f7 other than 0000000/0100000, or f7=0100000 with f3 other than 000/101;
  - SLLI with f7≠0, or SRLI/SRAI with f7 other than 0000000/0100000;
  - load with f3 ∈ {011,110,111};
  - store with f3 > 010;
  - branch with f3 ∈ {010,011};
  - JALR with f3≠000.
- EXEC: 1 cycle. Next state by class:
  - branch: pc_we=1, go to FETCH;
  - load/store: go to MEM;
  - all others: go to WB.
- MEM: dmem_req=1, DmWr=1 for stores only. On dmem_ready=1: a load goes to WB; a store asserts pc_we=1 and goes to FETCH.
- WB: RUWr=1, pc_we=1, go to FETCH.
- Retirement: instret increments by 1 on every cycle with pc_we=1 and wraps at 2**CNT_W. pc_we is asserted exactly once per retired instruction.
- Watchdog:
  - clears on entry to FETCH/MEM and on any ready;
  - increments each waiting cycle;
  - on reaching MEM_TIMEOUT with ready still 0: bus_err=1, go to TRAP, no strobe issued;
  - ready in the same cycle as the limit wins (no error).
- TRAP: all strobes and reqs 0, controls held. Exit only via rst.
- Latency with zero wait states:
  - branch 3 cycles;
  - R/I/U/JAL/JALR 4 cycles;
  - store 4 cycles;
  - load 5 cycles.
- ready inputs are ignored outside their owning state.

Decomposition:
- Shared package cu_pkg:
  - state enum;
  - opcode constants (OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC);
  - ImmSrc/AluOp/BrOp/RUDataWrSrc constants;
  - decoded-control struct.
- One combinational sub-module, cu_decode, turns opcode/f3/f7 into the control struct plus illegal and instruction class. It is reusable by a later pipelined core.

Test Plan:
- ADD (0110011/000/0000000), imem_ready=1 every cycle → states FETCH,DECODE,EXEC,WB; RUWr=1 only in WB; AluOp=0000; instret 0→1 after cycle 4.
- LW (0000011/010) with dmem_ready delayed 3 cycles → MEM held 4 cycles with dmem_req=1; DmCtrl=010; RUDataWrSrc=01; RUWr=1 one cycle; total 8 cycles.
- SW (0100011/010) → DmWr=1 only in MEM; RUWr never 1; ImmSrc=001; retires in 4 cycles.
- BGEU (1100011/111) → BrOp=01111, AluOp=1000; pc_we=1 in EXEC; next state FETCH; RUWr=0.
- Opcode 1111111, or SUB with f3=001/f7=0100000 → illegal=1, TRAP; no strobes; instret unchanged; rst returns to FETCH with illegal=0.
- MEM_TIMEOUT=4, imem_ready held 0 → bus_err=1 after 4 FETCH cycles; TRAP. Repeat with ready arriving on the 4th cycle → no error, proceeds to DECODE.

Source files
------------

// File: rtl/cu_pkg.sv
// Shared definitions for the multi-cycle RV32I control unit.
//   - state_t : control FSM states (also exported on the debug port)
//   - cls_t   : instruction class that selects the EXEC -> next-state path
//   - OP_*    : RV32I major opcodes
//   - IMM_*, ALU_*, BR_*, WB_* : datapath control encodings
//   - ctrl_t  : bundle of decoded datapath controls latched per instruction
package cu_pkg;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        CLS_ALU    = 2'd0,  // goes through WB
        CLS_LOAD   = 2'd1,
        CLS_STORE  = 2'd2,
        CLS_BRANCH = 2'd3
    } cls_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_U = 3'b011;
    localparam logic [2:0] IMM_J = 3'b100;

    localparam logic [3:0] ALU_ADD    = 4'b0000;
    localparam logic [3:0] ALU_BRANCH = 4'b1000;

    localparam logic [4:0] BR_NONE = 5'b00000;
    localparam logic [4:0] BR_JUMP = 5'b10000;
    localparam logic [1:0] BR_COND = 2'b01;   // prefix; low bits are funct3

    localparam logic [1:0] WB_ALU = 2'b00;
    localparam logic [1:0] WB_MEM = 2'b01;
    localparam logic [1:0] WB_PC4 = 2'b10;

    typedef struct packed {
        logic [2:0] imm_src;
        logic       alu_a_src;
        logic       alu_b_src;
        logic [3:0] alu_op;
        logic [4:0] br_op;
        logic [2:0] dm_ctrl;
        logic [1:0] wb_src;
    } ctrl_t;

endpackage

// File: rtl/cu_decode.sv
// Purely combinational RV32I instruction decoder.
// Ports:
//   opcode, funct3, funct7 : instruction fields from the IR
//   ctrl                   : decoded datapath controls (unlisted fields are 0)
//   cls                    : instruction class for sequencing
//   illegal                : encoding is not a supported RV32I instruction
// Kept free of state so a pipelined core can reuse it unchanged.
module cu_decode
    import cu_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    output ctrl_t      ctrl,
    output cls_t       cls,
    output logic       illegal
);

    logic f7_zero;
    logic f7_alt;   // SUB / SRA / SRAI form

    assign f7_zero = (funct7 == 7'b0000000);
    assign f7_alt  = (funct7 == 7'b0100000);

    always_comb begin
        // NOTE: every output gets a default before the case so no path can
        // leave a value unassigned and infer a latch.
        ctrl    = '0;
        cls     = CLS_ALU;
        illegal = 1'b0;

        case (opcode)
            OP_R: begin
                ctrl.alu_op = {funct7[5], funct3};
                illegal     = !(f7_zero || (f7_alt && (funct3 == 3'b000 || funct3 == 3'b101)));
            end
            OP_I: begin
                // Only the right shift uses funct7[5] to pick SRAI over SRLI.
                ctrl.alu_op    = {(funct3 == 3'b101) & funct7[5], funct3};
                ctrl.alu_b_src = 1'b1;
                if (funct3 == 3'b001)
                    illegal = !f7_zero;
                else if (funct3 == 3'b101)
                    illegal = !(f7_zero || f7_alt);
            end
            OP_LOAD: begin
                cls            = CLS_LOAD;
                ctrl.alu_b_src = 1'b1;
                ctrl.dm_ctrl   = funct3;
                ctrl.wb_src    = WB_MEM;
                illegal        = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
            end
            OP_STORE: begin
                cls            = CLS_STORE;
                ctrl.imm_src   = IMM_S;
                ctrl.alu_b_src = 1'b1;
                ctrl.dm_ctrl   = funct3;
                illegal        = (funct3 > 3'b010);
            end
            OP_BRANCH: begin
                cls          = CLS_BRANCH;
                ctrl.imm_src = IMM_B;
                ctrl.alu_op  = ALU_BRANCH;
                ctrl.br_op   = {BR_COND, funct3};
                illegal      = (funct3 == 3'b010) || (funct3 == 3'b011);
            end
            OP_JAL: begin
                ctrl.imm_src   = IMM_J;
                ctrl.alu_a_src = 1'b1;
                ctrl.alu_b_src = 1'b1;
                ctrl.br_op     = BR_JUMP;
                ctrl.wb_src    = WB_PC4;
            end
            OP_JALR: begin
                ctrl.alu_b_src = 1'b1;
                ctrl.br_op     = BR_JUMP;
                ctrl.wb_src    = WB_PC4;
                illegal        = (funct3 != 3'b000);
            end
            OP_LUI, OP_AUIPC: begin
                ctrl.imm_src   = IMM_U;
                ctrl.alu_a_src = 1'b1;
                ctrl.alu_b_src = 1'b1;
            end
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/cu_mc.sv
// Multi-cycle control unit for the RV32I core.
// Sequences FETCH -> DECODE -> EXEC -> (MEM) -> (WB), latches the decoded
// datapath controls once per instruction in DECODE and pulses write strobes
// only in the state that owns them. Illegal encodings and memory waits that
// exceed MEM_TIMEOUT cycles park the FSM in TRAP until reset.
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   opcode/funct3/funct7     : IR fields, valid from DECODE onward
//   imem_ready, dmem_ready   : memory handshakes (ignored outside their state)
//   imem_req, dmem_req       : memory requests
//   ir_we, pc_we, RUWr, DmWr : architectural write strobes
//   ImmSrc..RUDataWrSrc      : latched datapath controls
//   illegal, bus_err         : sticky error flags
//   instret                  : retired-instruction counter (wraps)
//   state_o                  : current FSM state for debug
module cu_mc
    import cu_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int TO_W        = 5,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [6:0]       opcode,
    input  logic [2:0]       funct3,
    input  logic [6:0]       funct7,
    input  logic             imem_ready,
    input  logic             dmem_ready,
    output logic             imem_req,
    output logic             dmem_req,
    output logic             ir_we,
    output logic             pc_we,
    output logic             RUWr,
    output logic             DmWr,
    output logic [2:0]       ImmSrc,
    output logic             AluAsrc,
    output logic             AluBsrc,
    output logic [3:0]       AluOp,
    output logic [4:0]       BrOp,
    output logic [2:0]       DmCtrl,
    output logic [1:0]       RUDataWrSrc,
    output logic             illegal,
    output logic             bus_err,
    output logic [CNT_W-1:0] instret,
    output logic [2:0]       state_o
);

    // The watchdog holds the number of waiting cycles already spent; the
    // limit is reached in the cycle where it would become MEM_TIMEOUT.
    localparam logic [TO_W-1:0] TO_LAST = TO_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

    state_t          state;
    state_t          next_state;
    ctrl_t           ctrl_q;
    ctrl_t           dec_ctrl;
    cls_t            cls_q;
    cls_t            dec_cls;
    logic            dec_illegal;
    logic [TO_W-1:0] wd;
    logic            wd_expired;
    logic            timeout;
    logic            is_store;

    cu_decode u_decode (
        .opcode  (opcode),
        .funct3  (funct3),
        .funct7  (funct7),
        .ctrl    (dec_ctrl),
        .cls     (dec_cls),
        .illegal (dec_illegal)
    );

    assign is_store   = (cls_q == CLS_STORE);
    assign wd_expired = (MEM_TIMEOUT != 0) && (wd == TO_LAST);

    always_comb begin
        next_state = state;
        imem_req   = 1'b0;
        dmem_req   = 1'b0;
        ir_we      = 1'b0;
        pc_we      = 1'b0;
        RUWr       = 1'b0;
        DmWr       = 1'b0;
        timeout    = 1'b0;

        case (state)
            S_FETCH: begin
                imem_req = 1'b1;
                if (imem_ready) begin
                    ir_we      = 1'b1;
                    next_state = S_DECODE;
                end else if (wd_expired) begin
                    timeout    = 1'b1;
                    next_state = S_TRAP;
                end
            end
            S_DECODE: next_state = dec_illegal ? S_TRAP : S_EXEC;
            S_EXEC: begin
                case (cls_q)
                    CLS_BRANCH: begin
                        pc_we      = 1'b1;
                        next_state = S_FETCH;
                    end
                    CLS_LOAD, CLS_STORE: next_state = S_MEM;
                    default:             next_state = S_WB;
                endcase
            end
            S_MEM: begin
                dmem_req = 1'b1;
                DmWr     = is_store;
                if (dmem_ready) begin
                    if (is_store) begin
                        pc_we      = 1'b1;
                        next_state = S_FETCH;
                    end else begin
                        next_state = S_WB;
                    end
                end else if (wd_expired) begin
                    timeout    = 1'b1;
                    next_state = S_TRAP;
                end
            end
            S_WB: begin
                RUWr       = 1'b1;
                pc_we      = 1'b1;
                next_state = S_FETCH;
            end
            default: ;  // TRAP: everything idle, leave only through reset
        endcase

        // Reset is sampled at the edge, so the state may still be WB/MEM in the
        // reset cycle; suppress strobes so an abandoned instruction never writes.
        if (rst) begin
            imem_req = 1'b0;
            dmem_req = 1'b0;
            ir_we    = 1'b0;
            pc_we    = 1'b0;
            RUWr     = 1'b0;
            DmWr     = 1'b0;
            timeout  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register updates from the same pre-edge values.
        if (rst) begin
            state   <= S_FETCH;
            ctrl_q  <= '0;
            cls_q   <= CLS_ALU;
            illegal <= 1'b0;
            bus_err <= 1'b0;
            instret <= '0;
            wd      <= '0;
        end else begin
            state <= next_state;

            if (state == S_DECODE) begin
                ctrl_q <= dec_ctrl;
                cls_q  <= dec_cls;
                if (dec_illegal)
                    illegal <= 1'b1;
            end

            if (timeout)
                bus_err <= 1'b1;

            if (pc_we)
                instret <= instret + 1'b1;

            // Counts only while stalled in a waiting state; any state change
            // (ready, entry into FETCH/MEM, trap) restarts it from zero.
            if ((state == S_FETCH || state == S_MEM) && next_state == state)
                wd <= wd + 1'b1;
            else
                wd <= '0;
        end
    end

    assign ImmSrc      = ctrl_q.imm_src;
    assign AluAsrc     = ctrl_q.alu_a_src;
    assign AluBsrc     = ctrl_q.alu_b_src;
    assign AluOp       = ctrl_q.alu_op;
    assign BrOp        = ctrl_q.br_op;
    assign DmCtrl      = ctrl_q.dm_ctrl;
    assign RUDataWrSrc = ctrl_q.wb_src;
    assign state_o     = state;

endmodule

// File: tb/tb_cu_mc.sv
// Directed self-checking bench for cu_mc (MEM_TIMEOUT=4, CNT_W=4 so the
// watchdog limit and counter wrap are reachable in a few cycles).
module tb_cu_mc;
    import cu_pkg::*;

    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic [6:0]       opcode;
    logic [2:0]       funct3;
    logic [6:0]       funct7;
    logic             imem_ready;
    logic             dmem_ready;
    logic             imem_req;
    logic             dmem_req;
    logic             ir_we;
    logic             pc_we;
    logic             RUWr;
    logic             DmWr;
    logic [2:0]       ImmSrc;
    logic             AluAsrc;
    logic             AluBsrc;
    logic [3:0]       AluOp;
    logic [4:0]       BrOp;
    logic [2:0]       DmCtrl;
    logic [1:0]       RUDataWrSrc;
    logic             illegal;
    logic             bus_err;
    logic [CNT_W-1:0] instret;
    logic [2:0]       state_o;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    cu_mc #(
        .MEM_TIMEOUT (4),
        .TO_W        (3),
        .CNT_W       (CNT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .opcode      (opcode),
        .funct3      (funct3),
        .funct7      (funct7),
        .imem_ready  (imem_ready),
        .dmem_ready  (dmem_ready),
        .imem_req    (imem_req),
        .dmem_req    (dmem_req),
        .ir_we       (ir_we),
        .pc_we       (pc_we),
        .RUWr        (RUWr),
        .DmWr        (DmWr),
        .ImmSrc      (ImmSrc),
        .AluAsrc     (AluAsrc),
        .AluBsrc     (AluBsrc),
        .AluOp       (AluOp),
        .BrOp        (BrOp),
        .DmCtrl      (DmCtrl),
        .RUDataWrSrc (RUDataWrSrc),
        .illegal     (illegal),
        .bus_err     (bus_err),
        .instret     (instret),
        .state_o     (state_o)
    );

    typedef struct packed {
        logic [6:0] op;
        logic [2:0] f3;
        logic [6:0] f7;
        logic       ill;
    } dec_vec_t;

    dec_vec_t tbl [0:17] = '{
        '{OP_R,      3'b000, 7'h00, 1'b0},   // ADD
        '{OP_R,      3'b000, 7'h20, 1'b0},   // SUB
        '{OP_R,      3'b101, 7'h20, 1'b0},   // SRA
        '{OP_R,      3'b001, 7'h20, 1'b1},   // alt f7 with f3=001
        '{OP_R,      3'b000, 7'h01, 1'b1},   // M-extension f7
        '{OP_I,      3'b101, 7'h20, 1'b0},   // SRAI
        '{OP_I,      3'b001, 7'h20, 1'b1},   // SLLI with f7!=0
        '{OP_I,      3'b101, 7'h01, 1'b1},   // SRLI with bad f7
        '{OP_LOAD,   3'b100, 7'h00, 1'b0},   // LBU
        '{OP_LOAD,   3'b011, 7'h00, 1'b1},
        '{OP_STORE,  3'b010, 7'h00, 1'b0},   // SW
        '{OP_STORE,  3'b011, 7'h00, 1'b1},
        '{OP_BRANCH, 3'b011, 7'h00, 1'b1},
        '{OP_BRANCH, 3'b100, 7'h00, 1'b0},   // BLT
        '{OP_JALR,   3'b000, 7'h00, 1'b0},
        '{OP_JALR,   3'b001, 7'h00, 1'b1},
        '{OP_AUIPC,  3'b000, 7'h00, 1'b0},
        '{7'b0000000, 3'b000, 7'h00, 1'b1}   // unknown opcode
    };

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Each cycle starts 1 time unit after the rising edge; inputs are driven
    // there and outputs are sampled 1 unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic ir, input logic dr);
        imem_ready = ir;
        dmem_ready = dr;
        #1;
    endtask

    task automatic set_instr(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7);
        opcode = op;
        funct3 = f3;
        funct7 = f7;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        imem_ready = 1'b0;
        dmem_ready = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    // From the start of a FETCH cycle: zero-wait fetch, decode, stop in EXEC.
    task automatic run_to_exec(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7);
        set_instr(op, f3, f7);
        set_in(1'b1, 1'b0);
        tick();
        set_in(1'b0, 1'b0);
        tick();
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL tb_timeout observed=running expected=finished");
        $fatal(1, "bench time limit exceeded");
    end

    initial begin
        rst = 1'b1;
        set_instr(7'b0, 3'b0, 7'b0);
        imem_ready = 1'b1;
        dmem_ready = 1'b1;
        tick();
        tick();
        #1;
        // ---- reset state (strobes gated while rst is high) ----
        check("rst_state",    state_o,  S_FETCH);
        check("rst_imem_req", imem_req, 1'b0);
        check("rst_ir_we",    ir_we,    1'b0);
        check("rst_instret",  instret,  '0);
        check("rst_illegal",  illegal,  1'b0);
        check("rst_bus_err",  bus_err,  1'b0);
        check("rst_aluop",    AluOp,    4'b0000);
        rst = 1'b0;

        // ---- ADD, zero wait states: F D E WB ----
        set_instr(OP_R, 3'b000, 7'h00);
        set_in(1'b1, 1'b0);
        check("add_f_state", state_o,  S_FETCH);
        check("add_f_req",   imem_req, 1'b1);
        check("add_f_irwe",  ir_we,    1'b1);
        tick();
        set_in(1'b1, 1'b1);  // readies outside their state must be ignored
        check("add_d_state", state_o,  S_DECODE);
        check("add_d_irwe",  ir_we,    1'b0);
        check("add_d_dreq",  dmem_req, 1'b0);
        tick();
        set_in(1'b0, 1'b0);
        check("add_e_state", state_o, S_EXEC);
        check("add_e_aluop", AluOp,   4'b0000);
        check("add_e_ruwr",  RUWr,    1'b0);
        check("add_e_pcwe",  pc_we,   1'b0);
        tick();
        check("add_w_state",   state_o, S_WB);
        check("add_w_ruwr",    RUWr,    1'b1);
        check("add_w_pcwe",    pc_we,   1'b1);
        check("add_w_instret", instret, 4'd0);
        tick();
        check("add_next_state", state_o, S_FETCH);
        check("add_instret",    instret, 4'd1);

        // ---- SRAI: arithmetic right shift immediate ----
        run_to_exec(OP_I, 3'b101, 7'h20);
        check("srai_aluop", AluOp,   4'b1101);
        check("srai_bsrc",  AluBsrc, 1'b1);
        check("srai_asrc",  AluAsrc, 1'b0);
        tick();
        tick();
        check("srai_instret", instret, 4'd2);

        // ---- LW with dmem_ready on the 4th MEM cycle (limit cycle: ready wins) ----
        run_to_exec(OP_LOAD, 3'b010, 7'h00);
        check("lw_dmctrl", DmCtrl,      3'b010);
        check("lw_wbsrc",  RUDataWrSrc, 2'b01);
        check("lw_bsrc",   AluBsrc,     1'b1);
        for (int i = 0; i < 3; i++) begin
            tick();
            set_in(1'b0, 1'b0);
            check("lw_mem_state", state_o,  S_MEM);
            check("lw_mem_dreq",  dmem_req, 1'b1);
            check("lw_mem_dmwr",  DmWr,     1'b0);
        end
        tick();
        set_in(1'b0, 1'b1);
        check("lw_m4_state", state_o, S_MEM);
        check("lw_m4_pcwe",  pc_we,   1'b0);
        tick();
        set_in(1'b0, 1'b0);
        check("lw_wb_state", state_o, S_WB);
        check("lw_wb_ruwr",  RUWr,    1'b1);
        check("lw_bus_err",  bus_err, 1'b0);
        tick();
        check("lw_ruwr_once", RUWr,    1'b0);
        check("lw_instret",   instret, 4'd3);

        // ---- SW: DmWr only in MEM, no register write ----
        run_to_exec(OP_STORE, 3'b010, 7'h00);
        check("sw_immsrc", ImmSrc, 3'b001);
        check("sw_e_dmwr", DmWr,   1'b0);
        check("sw_e_ruwr", RUWr,   1'b0);
        tick();
        set_in(1'b0, 1'b1);
        check("sw_m_dmwr", DmWr,  1'b1);
        check("sw_m_pcwe", pc_we, 1'b1);
        check("sw_m_ruwr", RUWr,  1'b0);
        tick();
        set_in(1'b0, 1'b0);
        check("sw_f_state", state_o, S_FETCH);
        check("sw_f_dmwr",  DmWr,    1'b0);
        check("sw_instret", instret, 4'd4);

        // ---- BGEU: retires from EXEC ----
        run_to_exec(OP_BRANCH, 3'b111, 7'h00);
        check("bgeu_brop",   BrOp,   5'b01111);
        check("bgeu_aluop",  AluOp,  4'b1000);
        check("bgeu_immsrc", ImmSrc, 3'b010);
        check("bgeu_pcwe",   pc_we,  1'b1);
        check("bgeu_ruwr",   RUWr,   1'b0);
        tick();
        check("bgeu_next",    state_o, S_FETCH);
        check("bgeu_instret", instret, 4'd5);

        // ---- JAL ----
        run_to_exec(OP_JAL, 3'b000, 7'h00);
        check("jal_immsrc", ImmSrc,      3'b100);
        check("jal_asrc",   AluAsrc,     1'b1);
        check("jal_brop",   BrOp,        5'b10000);
        check("jal_wbsrc",  RUDataWrSrc, 2'b10);
        tick();
        check("jal_wb_ruwr", RUWr, 1'b1);
        tick();

        // ---- LUI ----
        run_to_exec(OP_LUI, 3'b000, 7'h00);
        check("lui_immsrc", ImmSrc,      3'b011);
        check("lui_asrc",   AluAsrc,     1'b1);
        check("lui_brop",   BrOp,        5'b00000);
        check("lui_wbsrc",  RUDataWrSrc, 2'b00);
        tick();
        tick();
        check("lui_instret", instret, 4'd7);

        // ---- SUB then reset during WB: no write may escape ----
        run_to_exec(OP_R, 3'b000, 7'h20);
        check("sub_aluop", AluOp, 4'b1000);
        tick();
        rst = 1'b1;
        #1;
        check("rstwb_ruwr", RUWr,  1'b0);
        check("rstwb_pcwe", pc_we, 1'b0);
        tick();
        rst = 1'b0;
        #1;
        check("rstwb_state",   state_o, S_FETCH);
        check("rstwb_instret", instret, 4'd0);

        // ---- counter wrap: 16 branches with CNT_W=4 ----
        for (int i = 0; i < 16; i++) begin
            run_to_exec(OP_BRANCH, 3'b000, 7'h00);
            tick();
            check("wrap_instret", instret, 32'((i + 1) % 16));
        end

        // ---- opcode 1111111 after one retirement: trap, no strobes ----
        run_to_exec(OP_BRANCH, 3'b001, 7'h00);
        tick();
        set_instr(7'b1111111, 3'b000, 7'h00);
        set_in(1'b1, 1'b0);
        tick();
        tick();
        set_in(1'b1, 1'b1);
        check("ill_state",   state_o,  S_TRAP);
        check("ill_flag",    illegal,  1'b1);
        check("ill_imreq",   imem_req, 1'b0);
        check("ill_dmreq",   dmem_req, 1'b0);
        check("ill_irwe",    ir_we,    1'b0);
        check("ill_pcwe",    pc_we,    1'b0);
        tick();
        check("ill_hold",    state_o, S_TRAP);
        check("ill_instret", instret, 4'd1);
        apply_reset();
        #1;
        check("ill_rst_flag",  illegal, 1'b0);
        check("ill_rst_state", state_o, S_FETCH);

        // ---- decode legality table ----
        for (int i = 0; i < 18; i++) begin
            set_instr(tbl[i].op, tbl[i].f3, tbl[i].f7);
            set_in(1'b1, 1'b0);
            tick();
            set_in(1'b0, 1'b0);
            tick();
            #1;
            check($sformatf("dec%0d_state", i), state_o, tbl[i].ill ? S_TRAP : S_EXEC);
            check($sformatf("dec%0d_illegal", i), illegal, tbl[i].ill);
            apply_reset();
        end

        // ---- FETCH watchdog: imem_ready held low ----
        for (int i = 0; i < 4; i++) begin
            set_in(1'b0, 1'b0);
            check("wdf_state", state_o, S_FETCH);
            check("wdf_berr",  bus_err, 1'b0);
            tick();
        end
        #1;
        check("wdf_trap",  state_o,  S_TRAP);
        check("wdf_berr1", bus_err,  1'b1);
        check("wdf_imreq", imem_req, 1'b0);
        apply_reset();
        #1;
        check("wdf_rst_berr", bus_err, 1'b0);

        // ---- FETCH watchdog: ready on the 4th cycle wins ----
        for (int i = 0; i < 3; i++) begin
            set_in(1'b0, 1'b0);
            tick();
        end
        set_in(1'b1, 1'b0);
        check("wdr_state", state_o, S_FETCH);
        check("wdr_irwe",  ir_we,   1'b1);
        tick();
        set_in(1'b0, 1'b0);
        check("wdr_decode", state_o, S_DECODE);
        check("wdr_berr",   bus_err, 1'b0);
        apply_reset();

        // ---- MEM watchdog: load never completes ----
        run_to_exec(OP_LOAD, 3'b000, 7'h00);
        for (int i = 0; i < 4; i++) begin
            tick();
            set_in(1'b0, 1'b0);
            check("wdm_state", state_o, S_MEM);
        end
        tick();
        check("wdm_trap",    state_o, S_TRAP);
        check("wdm_berr",    bus_err, 1'b1);
        check("wdm_ruwr",    RUWr,    1'b0);
        check("wdm_instret", instret, 4'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
